bist_alu_controller: RTL and testbench

// - Sequences one BIST session on the ALU circuit-under-test (CUT): holds the CUT and its LFSR in reset, releases them, waits out pipeline fill, then compacts N responses into a MISR signature.
// - Compares the signature against a golden value and reports pass/fail; it sits between the top-level test request and the CUT/LFSR pair.
// - Single clock domain; the CUT response bus is the concatenation of all CUT outputs.

---
 rtl/bist_alu_controller.sv | 175 +++++++++++++++++
 tb/tb_bist_alu_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bist_alu_controller.sv
// bist_alu_controller: sequences one BIST session on the ALU circuit-under-test.
// It holds the CUT and its LFSR in reset, releases them, skips the pipeline fill,
// compacts N_PATTERNS responses into a MISR signature and compares that signature
// against golden_sig.
// Optional feature: define BIST_ABORT_EN to let `abort` end a running session early
// with a forced fail. When the macro is undefined, `abort` is present but ignored.
module bist_alu_controller #(
    parameter int               RESP_W     = 74,
    parameter int               SIG_W      = 16,
    parameter logic [SIG_W-1:0] MISR_POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] MISR_SEED  = 16'hFFFF,
    parameter int               N_PATTERNS = 255,
    parameter int               RST_CYC    = 2,
    parameter int               PIPE_LAT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [SIG_W-1:0]  golden_sig,
    input  logic [RESP_W-1:0] cut_resp,
    output logic              cut_reset,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [SIG_W-1:0]  signature
);

    // One shared phase counter is wide enough for the longest phase.
    localparam int MAX_AB    = (RST_CYC > PIPE_LAT) ? RST_CYC : PIPE_LAT;
    localparam int MAX_CYC   = (MAX_AB > N_PATTERNS) ? MAX_AB : N_PATTERNS;
    localparam int CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;
    localparam int FILL_LAST = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;
    localparam int NCHUNK    = (RESP_W + SIG_W - 1) / SIG_W;
    localparam int PAD_W     = NCHUNK * SIG_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FILL,
        S_CAPTURE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               cut_reset_q, cut_reset_d;
    logic [PAD_W-1:0]   resp_pad;
    logic [SIG_W-1:0]   fold;
    logic [SIG_W-1:0]   misr_next;

`ifndef BIST_ABORT_EN
    logic unused_abort;
    assign unused_abort = abort;
`endif

    assign resp_pad = PAD_W'(cut_resp);

    // Fold the response bus into one SIG_W word and advance the MISR by one step.
    always_comb begin
        fold = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            fold = fold ^ resp_pad[i*SIG_W +: SIG_W];
        end
        misr_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? MISR_POLY : '0) ^ fold;
    end

    // Session sequencing: next state, counter, signature and verdict, then the registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        pass_d  = pass_q;
        fail_d  = fail_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            S_INIT: begin
                sig_d = MISR_SEED;
                if (cnt_q == CNT_W'(RST_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = (PIPE_LAT == 0) ? S_CAPTURE : S_FILL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FILL: begin
                if (cnt_q == CNT_W'(FILL_LAST)) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                sig_d = misr_next;
                if (cnt_q == CNT_W'(N_PATTERNS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_COMPARE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_COMPARE: begin
                state_d = S_DONE;
                pass_d  = (sig_q == golden_sig);
                fail_d  = (sig_q != golden_sig);
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef BIST_ABORT_EN
        // An abort overrides everything else, including the compare verdict.
        if (abort && (state_q inside {S_INIT, S_FILL, S_CAPTURE, S_COMPARE})) begin
            state_d = S_DONE;
            cnt_d   = '0;
            sig_d   = sig_q;
            pass_d  = 1'b0;
            fail_d  = 1'b1;
        end
`endif

        done_d      = (state_d == S_DONE);
        busy_d      = (state_d inside {S_INIT, S_FILL, S_CAPTURE, S_COMPARE});
        cut_reset_d = !(state_d inside {S_FILL, S_CAPTURE, S_COMPARE});
    end

    // State and output registers; an asynchronous reset drops any session in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sig_q       <= MISR_SEED;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cut_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sig_q       <= sig_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            cut_reset_q <= cut_reset_d;
        end
    end

    assign cut_reset = cut_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_bist_alu_controller.sv
// tb_bist_alu_controller: directed sessions against two controller instances
// (default seed and zero seed) sharing the same stimulus.
module tb_bist_alu_controller;

    localparam int RESP_W     = 74;
    localparam int SIG_W      = 16;
    localparam int N_PATTERNS = 255;
    localparam int RST_CYC    = 2;
    localparam int PIPE_LAT   = 2;
    localparam int CAP_FIRST  = RST_CYC + PIPE_LAT + 1;
    localparam int DONE_EDGE  = 260;
    localparam int NONE       = -1000;
`ifdef BIST_ABORT_EN
    localparam bit ABORT_EN   = 1'b1;
`else
    localparam bit ABORT_EN   = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic [SIG_W-1:0]  golden_sig;
    logic [RESP_W-1:0] cut_resp;

    logic              d_cut_reset, d_busy, d_done, d_pass, d_fail;
    logic [SIG_W-1:0]  d_sig;
    logic              z_cut_reset, z_busy, z_done, z_pass, z_fail;
    logic [SIG_W-1:0]  z_sig;

    int vectors     = 0;
    int miscompares = 0;

    bist_alu_controller dut_d (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .golden_sig (golden_sig),
        .cut_resp   (cut_resp),
        .cut_reset  (d_cut_reset),
        .busy       (d_busy),
        .done       (d_done),
        .pass       (d_pass),
        .fail       (d_fail),
        .signature  (d_sig)
    );

    bist_alu_controller #(.MISR_SEED(16'h0000)) dut_z (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .golden_sig (golden_sig),
        .cut_resp   (cut_resp),
        .cut_reset  (z_cut_reset),
        .busy       (z_busy),
        .done       (z_done),
        .pass       (z_pass),
        .fail       (z_fail),
        .signature  (z_sig)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference MISR: each response bit i lands on fold bit (i mod 16).
    function automatic logic [15:0] modelSig(input logic [15:0] seed, input logic [73:0] base,
                                             input int flip_idx, input logic [73:0] flip_mask,
                                             input int count);
        logic [15:0] s;
        logic [15:0] f;
        logic [73:0] r;
        s = seed;
        for (int c = 0; c < count; c++) begin
            r = base ^ ((c == flip_idx) ? flip_mask : 74'h0);
            f = 16'h0;
            for (int b = 0; b < 74; b++) f[b % 16] = f[b % 16] ^ r[b];
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ f;
        end
        return s;
    endfunction

    // Runs one session from a start pulse (edge 0) and reports the edge at which done rose.
    task automatic applyStimulus(input logic [73:0] base, input int flip_idx, input logic [73:0] flip_mask,
                                 input int abort_idx, input bit hold_start, input logic [15:0] golden,
                                 output int done_edge);
        int c;
        golden_sig = golden;
        cut_resp   = base;
        abort      = 1'b0;
        start      = 1'b1;
        tick();
        done_edge = -1;
        for (int k = 1; k <= 400; k++) begin
            c        = k - CAP_FIRST;
            start    = hold_start;
            cut_resp = base ^ ((c == flip_idx) ? flip_mask : 74'h0);
            abort    = (c == abort_idx);
            tick();
            abort = 1'b0;
            if (k == 1) begin
                checkOutput("init_busy", 32'(d_busy), 32'd1);
                checkOutput("init_cut_reset", 32'(d_cut_reset), 32'd1);
                checkOutput("init_done", 32'(d_done), 32'd0);
                checkOutput("init_pass_cleared", 32'(d_pass), 32'd0);
                checkOutput("init_fail_cleared", 32'(z_fail), 32'd0);
            end
            if (k == RST_CYC) checkOutput("fill_cut_reset", 32'(d_cut_reset), 32'd0);
            if (d_done) begin
                done_edge = k;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (done_edge < 0) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [15:0] g;
        logic [15:0] gd;
        logic [15:0] gf;
        int          de;

        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        cut_resp   = '0;
        golden_sig = '0;
        tick();
        tick();
        checkOutput("rst_busy", 32'(d_busy), 32'd0);
        checkOutput("rst_done", 32'(d_done), 32'd0);
        checkOutput("rst_pass", 32'(d_pass), 32'd0);
        checkOutput("rst_fail", 32'(d_fail), 32'd0);
        checkOutput("rst_cut_reset", 32'(d_cut_reset), 32'd1);
        checkOutput("rst_sig_default", 32'(d_sig), 32'hFFFF);
        checkOutput("rst_sig_zero", 32'(z_sig), 32'h0000);
        reset = 1'b1;
        tick();
        checkOutput("idle_busy", 32'(d_busy), 32'd0);

        // Zero seed, zero responses, golden 0.
        applyStimulus(74'h0, NONE, 74'h0, NONE, 1'b0, 16'h0000, de);
        gd = modelSig(16'hFFFF, 74'h0, NONE, 74'h0, N_PATTERNS);
        checkOutput("a_done_edge", 32'(de), 32'(DONE_EDGE));
        checkOutput("a_z_pass", 32'(z_pass), 32'd1);
        checkOutput("a_z_fail", 32'(z_fail), 32'd0);
        checkOutput("a_z_sig", 32'(z_sig), 32'h0000);
        checkOutput("a_d_sig", 32'(d_sig), 32'(gd));
        checkOutput("a_d_fail", 32'(d_fail), 32'(gd != 16'h0000));
        checkOutput("a_d_busy", 32'(d_busy), 32'd0);
        checkOutput("a_d_cut_reset", 32'(d_cut_reset), 32'd1);

        // Re-run from DONE with golden 1.
        applyStimulus(74'h0, NONE, 74'h0, NONE, 1'b0, 16'h0001, de);
        checkOutput("b_done_edge", 32'(de), 32'(DONE_EDGE));
        checkOutput("b_z_pass", 32'(z_pass), 32'd0);
        checkOutput("b_z_fail", 32'(z_fail), 32'd1);

        // Constant response 1, golden from the reference model.
        g = modelSig(16'hFFFF, 74'h1, NONE, 74'h0, N_PATTERNS);
        applyStimulus(74'h1, NONE, 74'h0, NONE, 1'b0, g, de);
        checkOutput("c_done_edge", 32'(de), 32'(DONE_EDGE));
        checkOutput("c_sig", 32'(d_sig), 32'(g));
        checkOutput("c_pass", 32'(d_pass), 32'd1);
        checkOutput("c_fail", 32'(d_fail), 32'd0);

        // One flipped response bit in capture cycle 20.
        gf = modelSig(16'hFFFF, 74'h1, 20, 74'h1 << 37, N_PATTERNS);
        applyStimulus(74'h1, 20, 74'h1 << 37, NONE, 1'b0, g, de);
        checkOutput("d_sig_flip", 32'(d_sig), 32'(gf));
        checkOutput("d_pass_flip", 32'(d_pass), 32'd0);
        checkOutput("d_fail_flip", 32'(d_fail), 32'd1);

        // start held high through the whole session.
        applyStimulus(74'h1, NONE, 74'h0, NONE, 1'b1, g, de);
        checkOutput("e_done_edge", 32'(de), 32'(DONE_EDGE));
        checkOutput("e_pass", 32'(d_pass), 32'd1);
        tick();
        checkOutput("e_done_hold", 32'(d_done), 32'd1);
        checkOutput("e_busy_hold", 32'(d_busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("e_rerun_done", 32'(d_done), 32'd0);
        checkOutput("e_rerun_pass", 32'(d_pass), 32'd0);
        checkOutput("e_rerun_fail", 32'(d_fail), 32'd0);
        checkOutput("e_rerun_busy", 32'(d_busy), 32'd1);

        // Async reset during capture cycle 100 of that re-run.
        repeat (CAP_FIRST + 99) tick();
        checkOutput("r_busy_before", 32'(d_busy), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("r_busy", 32'(d_busy), 32'd0);
        checkOutput("r_done", 32'(d_done), 32'd0);
        checkOutput("r_pass", 32'(d_pass), 32'd0);
        checkOutput("r_fail", 32'(d_fail), 32'd0);
        checkOutput("r_cut_reset", 32'(d_cut_reset), 32'd1);
        checkOutput("r_sig_default", 32'(d_sig), 32'hFFFF);
        checkOutput("r_sig_zero", 32'(z_sig), 32'h0000);
        tick();
        reset = 1'b1;
        repeat (5) tick();
        checkOutput("r_idle_busy", 32'(d_busy), 32'd0);
        checkOutput("r_idle_done", 32'(d_done), 32'd0);
        checkOutput("r_idle_cut_reset", 32'(d_cut_reset), 32'd1);

        // Abort pulse in capture cycle 10.
        applyStimulus(74'h1, NONE, 74'h0, 10, 1'b0, g, de);
        checkOutput("x_done_edge", 32'(de), ABORT_EN ? 32'(CAP_FIRST + 10) : 32'(DONE_EDGE));
        checkOutput("x_pass", 32'(d_pass), ABORT_EN ? 32'd0 : 32'd1);
        checkOutput("x_fail", 32'(d_fail), ABORT_EN ? 32'd1 : 32'd0);
        checkOutput("x_cut_reset", 32'(d_cut_reset), 32'd1);
        checkOutput("x_sig", 32'(d_sig),
                    32'(modelSig(16'hFFFF, 74'h1, NONE, 74'h0, ABORT_EN ? 10 : N_PATTERNS)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
